// File: rtl/tournament_update_ctrl.sv
// Write sequencer for the tournament predictor's GBP/LBP/MBP 2-bit counter tables:
// init sweep after reset/flush, then saturating updates. Optional stats: BPRED_UPD_STATS_EN.
module tournament_update_ctrl #(
  parameter int         NR_ENTRIES = 64,
  parameter int         IDX_W      = $clog2(NR_ENTRIES),
  parameter logic [1:0] CTR_INIT   = 2'b01,
  parameter logic [1:0] MBP_INIT   = 2'b10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  output logic             init_done_o,
  input  logic             upd_valid_i,
  output logic             upd_ready_o,
  input  logic             upd_taken_i,
  input  logic [IDX_W-1:0] upd_gbp_idx_i,
  input  logic [IDX_W-1:0] upd_lbp_idx_i,
  input  logic [IDX_W-1:0] upd_mbp_idx_i,
  input  logic [1:0]       upd_gbp_ctr_i,
  input  logic [1:0]       upd_lbp_ctr_i,
  input  logic [1:0]       upd_mbp_ctr_i,
  output logic             gbp_we_o,
  output logic             lbp_we_o,
  output logic             mbp_we_o,
  output logic [IDX_W-1:0] gbp_widx_o,
  output logic [IDX_W-1:0] lbp_widx_o,
  output logic [IDX_W-1:0] mbp_widx_o,
  output logic [1:0]       gbp_wdata_o,
  output logic [1:0]       lbp_wdata_o,
`ifdef BPRED_UPD_STATS_EN
  output logic [31:0]      upd_cnt_o,
  output logic [31:0]      mispred_cnt_o,
`endif
  output logic [1:0]       mbp_wdata_o
);

  typedef enum logic {INIT, READY} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

  state_t           state_reg;
  logic [IDX_W-1:0] sweep_cnt_reg;

  logic       accept;
  logic [1:0] gbp_cur, lbp_cur, mbp_cur;
  logic       gbp_ok, lbp_ok;
  logic [1:0] gbp_next, lbp_next, mbp_next;
  logic       mbp_wr;

  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
    logic [1:0] res;
    res = ctr;
    if (up && ctr != 2'b11)
      res = ctr + 2'b01;
    else if (!up && ctr != 2'b00)
      res = ctr - 2'b01;
    return res;
  endfunction

  assign init_done_o = (state_reg == READY);
  assign upd_ready_o = (state_reg == READY) && !flush_i;
  assign accept      = upd_valid_i && upd_ready_o;

  // The counter supplied with the update may be stale if the same entry is being
  // written right now (sweep or previous update); forward the in-flight value.
  assign gbp_cur = (gbp_we_o && gbp_widx_o == upd_gbp_idx_i) ? gbp_wdata_o : upd_gbp_ctr_i;
  assign lbp_cur = (lbp_we_o && lbp_widx_o == upd_lbp_idx_i) ? lbp_wdata_o : upd_lbp_ctr_i;
  assign mbp_cur = (mbp_we_o && mbp_widx_o == upd_mbp_idx_i) ? mbp_wdata_o : upd_mbp_ctr_i;

  assign gbp_ok   = (gbp_cur[1] == upd_taken_i);
  assign lbp_ok   = (lbp_cur[1] == upd_taken_i);
  assign gbp_next = sat_step(gbp_cur, upd_taken_i);
  assign lbp_next = sat_step(lbp_cur, upd_taken_i);
  // Chooser only trains when exactly one component was right; towards that one.
  assign mbp_wr   = gbp_ok ^ lbp_ok;
  assign mbp_next = sat_step(mbp_cur, gbp_ok);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= INIT;
      sweep_cnt_reg <= '0;
      gbp_we_o      <= 1'b0;
      lbp_we_o      <= 1'b0;
      mbp_we_o      <= 1'b0;
      gbp_widx_o    <= '0;
      lbp_widx_o    <= '0;
      mbp_widx_o    <= '0;
      gbp_wdata_o   <= '0;
      lbp_wdata_o   <= '0;
      mbp_wdata_o   <= '0;
    end else begin
      gbp_we_o <= 1'b0;
      lbp_we_o <= 1'b0;
      mbp_we_o <= 1'b0;
      case (state_reg)
        INIT: begin
          if (flush_i) begin
            sweep_cnt_reg <= '0;
          end else begin
            gbp_we_o    <= 1'b1;
            lbp_we_o    <= 1'b1;
            mbp_we_o    <= 1'b1;
            gbp_widx_o  <= sweep_cnt_reg;
            lbp_widx_o  <= sweep_cnt_reg;
            mbp_widx_o  <= sweep_cnt_reg;
            gbp_wdata_o <= CTR_INIT;
            lbp_wdata_o <= CTR_INIT;
            mbp_wdata_o <= MBP_INIT;
            if (sweep_cnt_reg == LAST_IDX) begin
              state_reg     <= READY;
              sweep_cnt_reg <= '0;
            end else begin
              sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
            end
          end
        end
        READY: begin
          if (flush_i) begin
            state_reg     <= INIT;
            sweep_cnt_reg <= '0;
          end else if (accept) begin
            gbp_we_o    <= 1'b1;
            lbp_we_o    <= 1'b1;
            gbp_widx_o  <= upd_gbp_idx_i;
            lbp_widx_o  <= upd_lbp_idx_i;
            gbp_wdata_o <= gbp_next;
            lbp_wdata_o <= lbp_next;
            if (mbp_wr) begin
              mbp_we_o    <= 1'b1;
              mbp_widx_o  <= upd_mbp_idx_i;
              mbp_wdata_o <= mbp_next;
            end
          end
        end
        default: begin
          state_reg     <= INIT;
          sweep_cnt_reg <= '0;
        end
      endcase
    end
  end

`ifdef BPRED_UPD_STATS_EN
  logic mispred;

  // Misprediction is judged against whichever component the chooser selected.
  assign mispred = mbp_cur[1] ? !gbp_ok : !lbp_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      upd_cnt_o     <= '0;
      mispred_cnt_o <= '0;
    end else if (accept) begin
      upd_cnt_o <= upd_cnt_o + 32'd1;
      if (mispred)
        mispred_cnt_o <= mispred_cnt_o + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_tournament_update_ctrl.sv
// Directed bench for tournament_update_ctrl: sweep, updates with bypass, flush, async reset.
module tb_tournament_update_ctrl;
  localparam int N = 64;
  localparam int W = 6;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         flush_i = 1'b0;
  logic         init_done_o;
  logic         upd_valid_i = 1'b0;
  logic         upd_ready_o;
  logic         upd_taken_i = 1'b0;
  logic [W-1:0] upd_gbp_idx_i = '0, upd_lbp_idx_i = '0, upd_mbp_idx_i = '0;
  logic [1:0]   upd_gbp_ctr_i = '0, upd_lbp_ctr_i = '0, upd_mbp_ctr_i = '0;
  logic         gbp_we_o, lbp_we_o, mbp_we_o;
  logic [W-1:0] gbp_widx_o, lbp_widx_o, mbp_widx_o;
  logic [1:0]   gbp_wdata_o, lbp_wdata_o, mbp_wdata_o;
`ifdef BPRED_UPD_STATS_EN
  logic [31:0]  upd_cnt_o, mispred_cnt_o;
`endif

  tournament_update_ctrl #(.NR_ENTRIES(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .init_done_o(init_done_o),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o), .upd_taken_i(upd_taken_i),
    .upd_gbp_idx_i(upd_gbp_idx_i), .upd_lbp_idx_i(upd_lbp_idx_i), .upd_mbp_idx_i(upd_mbp_idx_i),
    .upd_gbp_ctr_i(upd_gbp_ctr_i), .upd_lbp_ctr_i(upd_lbp_ctr_i), .upd_mbp_ctr_i(upd_mbp_ctr_i),
    .gbp_we_o(gbp_we_o), .lbp_we_o(lbp_we_o), .mbp_we_o(mbp_we_o),
    .gbp_widx_o(gbp_widx_o), .lbp_widx_o(lbp_widx_o), .mbp_widx_o(mbp_widx_o),
    .gbp_wdata_o(gbp_wdata_o), .lbp_wdata_o(lbp_wdata_o),
`ifdef BPRED_UPD_STATS_EN
    .upd_cnt_o(upd_cnt_o), .mispred_cnt_o(mispred_cnt_o),
`endif
    .mbp_wdata_o(mbp_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic gw; logic [W-1:0] gi; logic [1:0] gd;
    logic lw; logic [W-1:0] li; logic [1:0] ld;
    logic mw; logic [W-1:0] mi; logic [1:0] md;
  } wr_t;

  wr_t exp_q[$];
  wr_t last_wr = '0;
  int  n_pass = 0;
  int  n_total = 0;
  int  exp_upd = 0;
  int  exp_mis = 0;

  function automatic logic [1:0] step(input logic [1:0] c, input logic up);
    int v;
    v = int'(c) + (up ? 1 : -1);
    if (v < 0) v = 0;
    if (v > 3) v = 3;
    return v[1:0];
  endfunction

  function automatic wr_t sweep_rec(input int i);
    wr_t e;
    e.gw = 1'b1; e.gi = W'(i); e.gd = 2'b01;
    e.lw = 1'b1; e.li = W'(i); e.ld = 2'b01;
    e.mw = 1'b1; e.mi = W'(i); e.md = 2'b10;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_wr(input string tag);
    wr_t e;
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    $display("txn %s: gbp we=%0b idx=%0d d=%0b lbp we=%0b idx=%0d d=%0b mbp we=%0b idx=%0d d=%0b",
             tag, gbp_we_o, gbp_widx_o, gbp_wdata_o, lbp_we_o, lbp_widx_o, lbp_wdata_o,
             mbp_we_o, mbp_widx_o, mbp_wdata_o);
    chk({tag, "_gbp_we"}, 32'(gbp_we_o), 32'(e.gw));
    chk({tag, "_lbp_we"}, 32'(lbp_we_o), 32'(e.lw));
    chk({tag, "_mbp_we"}, 32'(mbp_we_o), 32'(e.mw));
    if (e.gw) begin
      chk({tag, "_gbp_idx"}, 32'(gbp_widx_o), 32'(e.gi));
      chk({tag, "_gbp_data"}, 32'(gbp_wdata_o), 32'(e.gd));
    end
    if (e.lw) begin
      chk({tag, "_lbp_idx"}, 32'(lbp_widx_o), 32'(e.li));
      chk({tag, "_lbp_data"}, 32'(lbp_wdata_o), 32'(e.ld));
    end
    if (e.mw) begin
      chk({tag, "_mbp_idx"}, 32'(mbp_widx_o), 32'(e.mi));
      chk({tag, "_mbp_data"}, 32'(mbp_wdata_o), 32'(e.md));
    end
  endtask

  // Observes sweep writes 0..63 (or up to stop_at) one per cycle.
  task automatic run_sweep(input int stop_at);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(sweep_rec(i));
      @(negedge clk_i);
      chk_wr("sweep");
      chk("sweep_init_done", 32'(init_done_o), 32'(i == N - 1));
      chk("sweep_ready", 32'(upd_ready_o), 32'(i == N - 1));
      last_wr = sweep_rec(i);
      if (i == stop_at) return;
    end
  endtask

  task automatic do_upd(input logic t,
                        input logic [W-1:0] gi, input logic [1:0] gc,
                        input logic [W-1:0] li, input logic [1:0] lc,
                        input logic [W-1:0] mi, input logic [1:0] mc);
    wr_t e;
    logic [1:0] ge, le, me;
    logic gok, lok;
    upd_valid_i = 1'b1; upd_taken_i = t;
    upd_gbp_idx_i = gi; upd_gbp_ctr_i = gc;
    upd_lbp_idx_i = li; upd_lbp_ctr_i = lc;
    upd_mbp_idx_i = mi; upd_mbp_ctr_i = mc;
    #1 chk("upd_ready", 32'(upd_ready_o), 32'd1);
    ge = (last_wr.gw && last_wr.gi == gi) ? last_wr.gd : gc;
    le = (last_wr.lw && last_wr.li == li) ? last_wr.ld : lc;
    me = (last_wr.mw && last_wr.mi == mi) ? last_wr.md : mc;
    gok = (ge[1] == t);
    lok = (le[1] == t);
    e = '0;
    e.gw = 1'b1; e.gi = gi; e.gd = step(ge, t);
    e.lw = 1'b1; e.li = li; e.ld = step(le, t);
    if (gok != lok) begin
      e.mw = 1'b1; e.mi = mi; e.md = step(me, gok);
    end
    exp_upd++;
    if (me[1] ? !gok : !lok) exp_mis++;
    exp_q.push_back(e);
    @(negedge clk_i);
    chk_wr("upd");
    last_wr = e;
  endtask

  task automatic idle();
    upd_valid_i = 1'b0;
    exp_q.push_back('0);
    @(negedge clk_i);
    chk_wr("idle");
    last_wr = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_gbp_we", 32'(gbp_we_o), 0);
    chk("rst_lbp_we", 32'(lbp_we_o), 0);
    chk("rst_mbp_we", 32'(mbp_we_o), 0);
    chk("rst_widx", 32'({gbp_widx_o, lbp_widx_o, mbp_widx_o}), 0);
    chk("rst_wdata", 32'({gbp_wdata_o, lbp_wdata_o, mbp_wdata_o}), 0);
    chk("rst_init_done", 32'(init_done_o), 0);
    chk("rst_ready", 32'(upd_ready_o), 0);
    rst_i = 1'b0;
    run_sweep(-1);

    // Update racing the final sweep write: all three tables forward the sweep value.
    do_upd(1'b0, 6'd63, 2'b11, 6'd63, 2'b11, 6'd63, 2'b00);
    do_upd(1'b1, 6'd5, 2'b11, 6'd5, 2'b01, 6'd5, 2'b10);
    idle();
    do_upd(1'b1, 6'd7, 2'b00, 6'd8, 2'b00, 6'd9, 2'b11);
    do_upd(1'b1, 6'd7, 2'b00, 6'd8, 2'b00, 6'd9, 2'b11);
    do_upd(1'b0, 6'd10, 2'b00, 6'd11, 2'b00, 6'd12, 2'b01);
    do_upd(1'b1, 6'd13, 2'b01, 6'd14, 2'b10, 6'd15, 2'b00);
    do_upd(1'b1, 6'd16, 2'b00, 6'd17, 2'b11, 6'd18, 2'b11);
    idle();

    // Flush together with a valid update: update dropped, sweep restarts.
    upd_valid_i = 1'b1; flush_i = 1'b1;
    #1 chk("flush_ready", 32'(upd_ready_o), 0);
    exp_q.push_back('0);
    @(negedge clk_i);
    chk_wr("flush");
    chk("flush_init_done", 32'(init_done_o), 0);
    flush_i = 1'b0; upd_valid_i = 1'b0; last_wr = '0;
    run_sweep(30);

    flush_i = 1'b1;
    exp_q.push_back('0);
    @(negedge clk_i);
    chk_wr("midflush");
    flush_i = 1'b0;
    run_sweep(-1);

`ifdef BPRED_UPD_STATS_EN
    chk("stats_upd_cnt", upd_cnt_o, 32'(exp_upd));
    chk("stats_mispred_cnt", mispred_cnt_o, 32'(exp_mis));
`endif

    // Asynchronous reset while an update write is on the outputs.
    upd_valid_i = 1'b1; upd_taken_i = 1'b1;
    upd_gbp_idx_i = 6'd20; upd_gbp_ctr_i = 2'b01;
    @(posedge clk_i);
    #1 chk("pre_rst_gbp_we", 32'(gbp_we_o), 1);
    rst_i = 1'b1;
    #1;
    chk("async_rst_we", 32'({gbp_we_o, lbp_we_o, mbp_we_o}), 0);
    chk("async_rst_widx", 32'({gbp_widx_o, lbp_widx_o, mbp_widx_o}), 0);
    chk("async_rst_wdata", 32'({gbp_wdata_o, lbp_wdata_o, mbp_wdata_o}), 0);
    chk("async_rst_init_done", 32'(init_done_o), 0);
    chk("async_rst_ready", 32'(upd_ready_o), 0);
`ifdef BPRED_UPD_STATS_EN
    chk("async_rst_upd_cnt", upd_cnt_o, 0);
    chk("async_rst_mispred_cnt", mispred_cnt_o, 0);
`endif
    upd_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
